cfg_stream_loader: RTL and testbench

// - Configuration loader directly upstream of the fabric's ShiftLatch config chain.
// - Accepts a byte stream (valid/ready), waits for a sync byte, then shifts exactly CHAIN_LEN bits

---
 rtl/cfg_stream_loader_if.sv | 9 +
 rtl/cfg_stream_loader.sv | 197 +++++++++++++++++++
 tb/tb_cfg_stream_loader.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_stream_loader_if.sv
// Byte stream handshake into cfg_stream_loader; a byte transfers when in_valid & in_ready.
interface cfg_stream_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/cfg_stream_loader.sv
// Serial loader for the ShiftLatch config chain: hunts for SYNC_BYTE, then shifts CHAIN_LEN bits LSB-first.
// Optional trailing XOR checksum byte is enabled by defining CFG_CHECKSUM_EN.
module cfg_stream_loader #(
  parameter int         CHAIN_LEN = 64,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic               clock,
  input  logic               reset,
  cfg_stream_loader_if.slave in_if,
  output logic               cfg_bit,
  output logic               cfg_shift,
  output logic               cfg_done,
  output logic               cfg_error
);

  // Wide enough to hold CHAIN_LEN and to compare against 8 even for tiny chains.
  localparam int BLW = $clog2(CHAIN_LEN + 9);

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
`ifdef CFG_CHECKSUM_EN
    CHECK = 3'd5,
`endif
    ERROR = 3'd4
  } state_t;

  state_t         state_r, state_s;
  logic [7:0]     sreg_r, sreg_s;
  logic [3:0]     n_r, n_s;
  logic [BLW-1:0] bits_left_r, bits_left_s;
  logic           ready_r, ready_s;
  logic           shift_r, shift_s;
  logic           bit_r, bit_s;
  logic           done_r, done_s;
  logic           error_r, error_s;
  logic           xfer_s;
  logic           sync_s;
`ifdef CFG_CHECKSUM_EN
  logic [7:0]     csum_r, csum_s;
`endif

  function automatic logic [3:0] chunk_len(input logic [BLW-1:0] left);
    if (left >= BLW'(8)) begin
      return 4'd8;
    end else begin
      return left[3:0];
    end
  endfunction

  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  assign xfer_s = in_if.in_valid & ready_r;
  assign sync_s = xfer_s & (in_if.in_data == SYNC_BYTE);

  // Next-state decode; every output is registered from the values computed here.
  always_comb begin
    state_s     = state_r;
    sreg_s      = sreg_r;
    n_s         = n_r;
    bits_left_s = bits_left_r;
    shift_s     = 1'b0;
    bit_s       = 1'b0;
    done_s      = done_r;
    error_s     = error_r;
`ifdef CFG_CHECKSUM_EN
    csum_s      = csum_r;
`endif
    case (state_r)
      HUNT: begin
        if (sync_s) begin
          state_s     = LOAD;
          bits_left_s = BLW'(CHAIN_LEN);
`ifdef CFG_CHECKSUM_EN
          csum_s      = 8'h00;
`endif
        end else begin
          state_s = HUNT;
        end
      end
      LOAD: begin
        if (xfer_s) begin
          state_s = SHIFT;
          sreg_s  = in_if.in_data;
          n_s     = chunk_len(bits_left_r);
          shift_s = 1'b1;
          bit_s   = in_if.in_data[0];
`ifdef CFG_CHECKSUM_EN
          csum_s  = xor_fold(csum_r, in_if.in_data);
`endif
        end else begin
          state_s = LOAD;
        end
      end
      SHIFT: begin
        // The bit on cfg_bit now is sreg_r[0]; queue up sreg_r[1] for the next shift.
        sreg_s      = {1'b0, sreg_r[7:1]};
        n_s         = n_r - 4'd1;
        bits_left_s = bits_left_r - BLW'(1);
        if (n_r > 4'd1) begin
          state_s = SHIFT;
          shift_s = 1'b1;
          bit_s   = sreg_r[1];
        end else if (bits_left_r == BLW'(1)) begin
`ifdef CFG_CHECKSUM_EN
          state_s = CHECK;
`else
          state_s = DONE;
          done_s  = 1'b1;
`endif
        end else begin
          state_s = LOAD;
        end
      end
`ifdef CFG_CHECKSUM_EN
      CHECK: begin
        if (xfer_s) begin
          if (in_if.in_data == csum_r) begin
            state_s = DONE;
            done_s  = 1'b1;
          end else begin
            state_s = ERROR;
            error_s = 1'b1;
          end
        end else begin
          state_s = CHECK;
        end
      end
`endif
      DONE, ERROR: begin
        if (sync_s) begin
          state_s     = LOAD;
          done_s      = 1'b0;
          error_s     = 1'b0;
          bits_left_s = BLW'(CHAIN_LEN);
`ifdef CFG_CHECKSUM_EN
          csum_s      = 8'h00;
`endif
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = HUNT;
        done_s  = 1'b0;
        error_s = 1'b0;
      end
    endcase
    ready_s = (state_s != SHIFT);
  end

  // State and output registers; reset aborts a load in progress without touching the chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= HUNT;
      sreg_r      <= 8'h00;
      n_r         <= 4'd0;
      bits_left_r <= '0;
      ready_r     <= 1'b0;
      shift_r     <= 1'b0;
      bit_r       <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      csum_r      <= 8'h00;
`endif
    end else begin
      state_r     <= state_s;
      sreg_r      <= sreg_s;
      n_r         <= n_s;
      bits_left_r <= bits_left_s;
      ready_r     <= ready_s;
      shift_r     <= shift_s;
      bit_r       <= bit_s;
      done_r      <= done_s;
      error_r     <= error_s;
`ifdef CFG_CHECKSUM_EN
      csum_r      <= csum_s;
`endif
    end
  end

  assign in_if.in_ready = ready_r;
  assign cfg_bit        = bit_r;
  assign cfg_shift      = shift_r;
  assign cfg_done       = done_r;
`ifdef CFG_CHECKSUM_EN
  assign cfg_error      = error_r;
`else
  assign cfg_error      = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Randomized bench for cfg_stream_loader: expected chain bits come from payload bytes by plain indexing.
module tb_cfg_stream_loader;
  localparam int         CHAIN_LEN = 12;
  localparam int         NBYTES    = (CHAIN_LEN + 7) / 8;
  localparam logic [7:0] SYNC      = 8'hA5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic cfg_bit, cfg_shift, cfg_done, cfg_error;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_shift_cyc = 0;
  logic shift_q[$];
  logic [7:0] pay [NBYTES];

  cfg_stream_loader_if in_if ();

  cfg_stream_loader #(.CHAIN_LEN(CHAIN_LEN), .SYNC_BYTE(SYNC)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_if     (in_if),
    .cfg_bit   (cfg_bit),
    .cfg_shift (cfg_shift),
    .cfg_done  (cfg_done),
    .cfg_error (cfg_error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Chain-side monitor: record every shifted bit; cfg_bit must be 0 whenever no shift.
  always @(negedge clock) begin
    if (cfg_shift === 1'b1) begin
      shift_q.push_back(cfg_bit);
      last_shift_cyc = cyc;
    end else if (!reset) begin
      checks++;
      if (cfg_bit !== 1'b0) begin
        errors++;
        $display("FAIL idle_bit: cfg_bit=%b with cfg_shift=%b at cycle %0d, required 0", cfg_bit, cfg_shift, cyc);
      end
    end
`ifndef CFG_CHECKSUM_EN
    if (!reset) begin
      checks++;
      if (cfg_error !== 1'b0) begin
        errors++;
        $display("FAIL error_tied: cfg_error=%b at cycle %0d, required 0", cfg_error, cyc);
      end
    end
`endif
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic int chunk(input int k);
    return (CHAIN_LEN - 8 * k >= 8) ? 8 : CHAIN_LEN - 8 * k;
  endfunction

  function automatic logic [7:0] rand_non_sync();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == SYNC) b = 8'h00;
    return b;
  endfunction

  task automatic wait_ready();
    int w;
    for (w = 0; w < 100; w++) begin
      if (in_if.in_ready === 1'b1) break;
      @(negedge clock);
    end
    if (w == 100) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready=%b after 100 cycles, required 1", in_if.in_ready);
    end
  endtask

  // Present byte now and hold it until accepted; returns the cycle of the transfer.
  task automatic send_byte(input logic [7:0] b, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    in_if.in_data  = b;
    in_if.in_valid = 1'b1;
    for (int w = 0; w < 100 && !got; w++) begin
      if (w > 0) @(negedge clock);
      if (in_if.in_ready === 1'b1) begin
        got = 1'b1;
        acc = cyc;
      end
    end
    @(posedge clock);
    #1;
    in_if.in_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %h not accepted in 100 cycles, required acceptance", b);
    end
  endtask

  task automatic run_load(input int stall, input bit bad_ck);
    int a_prev, a_cur, done_cyc, nbad, bad_idx, w;
    logic exp_err;
    logic [7:0] x;
    exp_err = 1'b0;
    shift_q.delete();
    send_byte(SYNC, a_prev);
    @(negedge clock);
    checks++;
    if (cfg_done !== 1'b0 || cfg_error !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear: done=%b error=%b after sync, required 0 0", cfg_done, cfg_error);
    end
    for (int i = 0; i < NBYTES; i++) begin
      if (stall > 0 && i > 0) begin
        wait_ready();
        for (int s = 0; s < stall; s++) begin
          @(negedge clock);
          checks++;
          if (cfg_shift !== 1'b0) begin
            errors++;
            $display("FAIL stall_shift: cfg_shift=%b during stall cycle %0d, required 0", cfg_shift, s);
          end
        end
      end
      send_byte(pay[i], a_cur);
      if (stall == 0) begin
        checks++;
        if (a_cur - a_prev !== ((i == 0) ? 1 : chunk(i - 1) + 1)) begin
          errors++;
          $display("FAIL accept_spacing: byte %0d accepted %0d cycles after previous, required %0d",
                   i, a_cur - a_prev, (i == 0) ? 1 : chunk(i - 1) + 1);
        end
      end
      a_prev = a_cur;
      @(negedge clock);
      checks++;
      if (cfg_shift !== 1'b1) begin
        errors++;
        $display("FAIL accept_to_shift: cfg_shift=%b one cycle after byte %0d accept, required 1", cfg_shift, i);
      end
    end
`ifdef CFG_CHECKSUM_EN
    exp_err = bad_ck;
    wait_ready();
    checks++;
    if (cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL check_pending: cfg_done=%b while checksum pending, required 0", cfg_done);
    end
    x = 8'h00;
    for (int i = 0; i < NBYTES; i++) x = x ^ pay[i];
    if (bad_ck) x = x ^ 8'($urandom_range(255, 1));
    send_byte(x, a_cur);
`endif
    for (w = 0; w < 60; w++) begin
      if (cfg_done === 1'b1 || cfg_error === 1'b1) break;
      @(negedge clock);
    end
    done_cyc = cyc;
    checks++;
    if (w == 60) begin
      errors++;
      $display("FAIL done_timeout: done=%b error=%b after 60 cycles, required a completion", cfg_done, cfg_error);
    end
    checks++;
    if (shift_q.size() !== CHAIN_LEN) begin
      errors++;
      $display("FAIL shift_count: %0d shifts, required %0d", shift_q.size(), CHAIN_LEN);
    end
    nbad = 0;
    bad_idx = -1;
    for (int i = 0; i < CHAIN_LEN && i < shift_q.size(); i++) begin
      logic [7:0] pb;
      pb = pay[i / 8];
      if (shift_q[i] !== pb[i % 8]) begin
        nbad++;
        if (bad_idx < 0) bad_idx = i;
      end
    end
    checks++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL bit_sequence: %0d wrong bits, first at index %0d, required 0 wrong", nbad, bad_idx);
    end
`ifndef CFG_CHECKSUM_EN
    checks++;
    if (done_cyc !== last_shift_cyc + 1) begin
      errors++;
      $display("FAIL done_latency: cfg_done at cycle %0d, required %0d", done_cyc, last_shift_cyc + 1);
    end
`endif
    checks++;
    if (cfg_done !== !exp_err || cfg_error !== exp_err) begin
      errors++;
      $display("FAIL final_flags: done=%b error=%b, required %b %b", cfg_done, cfg_error, !exp_err, exp_err);
    end
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < NBYTES; i++) pay[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    in_if.in_data  = 8'h00;
    in_if.in_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (in_if.in_ready !== 1'b0 || cfg_shift !== 1'b0 || cfg_bit !== 1'b0 ||
        cfg_done !== 1'b0 || cfg_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b shift=%b bit=%b done=%b error=%b, required all 0",
               in_if.in_ready, cfg_shift, cfg_bit, cfg_done, cfg_error);
    end
    reset = 1'b0;
  endtask

  task automatic test_hunt();
    logic [7:0] junk [4];
    int a;
    junk[0] = 8'h00;
    junk[1] = 8'hFF;
    junk[2] = rand_non_sync();
    junk[3] = rand_non_sync();
    shift_q.delete();
    for (int i = 0; i < 4; i++) send_byte(junk[i], a);
    repeat (2) @(negedge clock);
    checks++;
    if (shift_q.size() !== 0 || cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL hunt_drop: %0d shifts done=%b after non-sync bytes, required 0 shifts done=0",
               shift_q.size(), cfg_done);
    end
    randomize_payload();
    run_load(0, 1'b0);
  endtask

  task automatic test_spec_vector();
    pay[0] = 8'h3C;
    pay[1] = 8'hF5;
    run_load(0, 1'b0);
  endtask

  task automatic test_done_drop();
    logic [7:0] b;
    int a;
    for (int i = 0; i < 2; i++) begin
      b = (i == 0) ? 8'h55 : rand_non_sync();
      shift_q.delete();
      send_byte(b, a);
      @(negedge clock);
      checks++;
      if (cfg_done !== 1'b1 || shift_q.size() !== 0) begin
        errors++;
        $display("FAIL done_drop: byte %h gave done=%b shifts=%0d, required done=1 shifts=0", b, cfg_done, shift_q.size());
      end
    end
    randomize_payload();
    run_load(0, 1'b0);
  endtask

  task automatic test_stall();
    randomize_payload();
    run_load(20, 1'b0);
  endtask

  task automatic test_reset_midload();
    int a;
    randomize_payload();
    send_byte(SYNC, a);
    send_byte(pay[0], a);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (cfg_shift !== 1'b0 || cfg_done !== 1'b0 || in_if.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset: shift=%b done=%b ready=%b, required 0 0 0", cfg_shift, cfg_done, in_if.in_ready);
    end
    reset = 1'b0;
    randomize_payload();
    run_load(0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      randomize_payload();
      run_load($urandom_range(3, 0), 1'b0);
    end
  endtask

`ifdef CFG_CHECKSUM_EN
  task automatic test_checksum();
    randomize_payload();
    run_load(0, 1'b0);
    randomize_payload();
    run_load(0, 1'b1);
    randomize_payload();
    run_load(0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_hunt();
    test_spec_vector();
    test_done_drop();
    test_stall();
    test_reset_midload();
    test_random();
`ifdef CFG_CHECKSUM_EN
    test_checksum();
`endif
    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
